// File: rtl/serial_word_receiver.sv
// serial_word_receiver
//   Collects a framed, LSB-first serial bit stream into a WIDTH-bit word and
//   presents it on a double-buffered parallel port with a valid/ready
//   handshake. A new frame can shift in while the previous word waits.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   sin        serial data bit
//   sin_valid  sin is sampled on this edge
//   start      first bit of a frame (only with sin_valid)
//   out_ready  consumer takes p_out on this edge
//   ovr_clr    clears the sticky overrun flag
//   p_out      last completed word
//   out_valid  p_out holds an unconsumed word
//   overrun    sticky: a completed word was dropped
//   busy       a frame is in progress
//   bit_count  bits accepted in the current frame
module serial_word_receiver #(
    parameter int WIDTH = 32  // 2..32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sin,
    input  logic             sin_valid,
    input  logic             start,
    input  logic             out_ready,
    input  logic             ovr_clr,
    output logic [WIDTH-1:0] p_out,
    output logic             out_valid,
    output logic             overrun,
    output logic             busy,
    output logic [5:0]       bit_count
);

    localparam logic [5:0] LAST = 6'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] sreg_nxt;
    logic             accept;    // bit shifts into sreg this edge
    logic             restart;   // bit becomes bit 0 of a fresh frame
    logic             complete;  // this accept finishes the word
    logic             load;      // completed word moves into p_out

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        restart   = 1'b0;
        complete  = 1'b0;
        case (state)
            IDLE: begin
                // Bits outside a frame are dropped until a start bit shows up.
                if (sin_valid && start) begin
                    accept    = 1'b1;
                    restart   = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (sin_valid) begin
                    accept = 1'b1;
                    if (start) begin
                        // Stale partial frame is simply overwritten by the
                        // next WIDTH shifts; nothing else to clean up.
                        restart = 1'b1;
                    end else if (bit_count == LAST) begin
                        complete  = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign sreg_nxt = {sin, sreg[WIDTH-1:1]};
    // A word still pending may be taken on the completion edge itself,
    // which frees the buffer for the new word.
    assign load     = complete && (!out_valid || out_ready);
    assign busy     = (state == SHIFT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sreg      <= '0;
            bit_count <= '0;
            p_out     <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (accept) sreg <= sreg_nxt;

            if (restart)       bit_count <= 6'd1;
            else if (complete) bit_count <= '0;
            else if (accept)   bit_count <= bit_count + 6'd1;

            if (load) begin
                p_out     <= sreg_nxt;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            // Set beats clear when both land on the same edge.
            if (complete && out_valid && !out_ready) overrun <= 1'b1;
            else if (ovr_clr)                         overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_serial_word_receiver.sv
// tb_serial_word_receiver
//   Directed bench for serial_word_receiver. Words expected on p_out are
//   pushed to a scoreboard queue when their frame is driven and popped when
//   the frame completes.
module tb_serial_word_receiver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sin = 1'b0;
    logic        sin_valid = 1'b0;
    logic        start = 1'b0;
    logic        out_ready = 1'b0;
    logic        ovr_clr = 1'b0;
    logic [31:0] p_out;
    logic        out_valid;
    logic        overrun;
    logic        busy;
    logic [5:0]  bit_count;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];
    int          busy_hi;
    logic [5:0]  pre_last_cnt;

    serial_word_receiver #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (rst_n),
        .sin       (sin),
        .sin_valid (sin_valid),
        .start     (start),
        .out_ready (out_ready),
        .ovr_clr   (ovr_clr),
        .p_out     (p_out),
        .out_valid (out_valid),
        .overrun   (overrun),
        .busy      (busy),
        .bit_count (bit_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Pop the next expected word and compare it with p_out.
    task automatic check_out(input string tag);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s observed=%h expected=<empty scoreboard>", tag, p_out);
        end else begin
            e = exp_q.pop_front();
            chk(tag, p_out, e);
        end
    endtask

    // One clock: inputs change on the falling edge, outputs sampled 1 unit
    // after the rising edge.
    task automatic cycle(input logic b, input logic sv, input logic st,
                         input logic rdy, input logic clr);
        @(negedge clk);
        sin = b; sin_valid = sv; start = st; out_ready = rdy; ovr_clr = clr;
        @(posedge clk);
        #1;
        sin_valid = 1'b0; start = 1'b0; out_ready = 1'b0; ovr_clr = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap, input logic rdy_last);
        busy_hi = 0;
        for (int i = 0; i < 32; i++) begin
            if (i > 0) repeat (gap) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            if (i == 31) pre_last_cnt = bit_count;
            cycle(w[i], 1'b1, (i == 0), rdy_last && (i == 31), 1'b0);
            if (i < 31 && busy) busy_hi++;
        end
    endtask

    initial begin
        // ---- reset ----
        #12;
        chk("rst_p_out", p_out, 32'h0);
        chk("rst_flags", {28'h0, out_valid, overrun, busy, 1'b0}, 32'h0);
        chk("rst_bit_count", {26'h0, bit_count}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 7; i++) cycle(1'($urandom), 1'b1, (i == 0), 1'($urandom), 1'b0);
        chk("mid_bit_count", {26'h0, bit_count}, 32'd7);
        chk("mid_busy", {31'h0, busy}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_bit_count", {26'h0, bit_count}, 32'h0);
        chk("async_rst_flags", {28'h0, out_valid, overrun, busy, 1'b0}, 32'h0);
        chk("async_rst_p_out", p_out, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) cycle(1'($urandom), 1'b1, 1'b0, 1'b0, 1'b0);
        chk("nostart_busy", {31'h0, busy}, 32'd0);
        chk("nostart_bit_count", {26'h0, bit_count}, 32'd0);
        chk("nostart_out_valid", {31'h0, out_valid}, 32'd0);

        // ---- basic frame ----
        exp_q.push_back(32'hDEADBEEF);
        send_word(32'hDEADBEEF, 0, 1'b0);
        chk("basic_busy_cycles", busy_hi, 32'd31);
        chk("basic_busy_after", {31'h0, busy}, 32'd0);
        chk("basic_out_valid", {31'h0, out_valid}, 32'd1);
        check_out("basic_p_out");
        chk("basic_bit_count", {26'h0, bit_count}, 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("basic_consumed", {31'h0, out_valid}, 32'd0);
        chk("basic_p_out_hold", p_out, 32'hDEADBEEF);

        // ---- gapped input ----
        exp_q.push_back(32'h80000001);
        send_word(32'h80000001, 2, 1'b0);
        chk("gap_pre_last_count", {26'h0, pre_last_cnt}, 32'd31);
        check_out("gap_p_out");
        chk("gap_overrun", {31'h0, overrun}, 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("gap_consumed", {31'h0, out_valid}, 32'd0);

        // ---- overrun ----
        exp_q.push_back(32'h12345678);
        send_word(32'h12345678, 0, 1'b0);
        send_word(32'hCAFEBABE, 0, 1'b0);
        check_out("ovr_p_out");
        chk("ovr_flag", {31'h0, overrun}, 32'd1);
        chk("ovr_out_valid", {31'h0, out_valid}, 32'd1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("ovr_cleared", {31'h0, overrun}, 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("ovr_consumed", {31'h0, out_valid}, 32'd0);

        // ---- simultaneous consume and complete ----
        exp_q.push_back(32'h11111111);
        send_word(32'h11111111, 0, 1'b0);
        check_out("sim_first");
        exp_q.push_back(32'h22222222);
        send_word(32'h22222222, 0, 1'b1);
        check_out("sim_second");
        chk("sim_out_valid", {31'h0, out_valid}, 32'd1);
        chk("sim_overrun", {31'h0, overrun}, 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // ---- restart mid-frame ----
        for (int i = 0; i < 10; i++) cycle(1'($urandom), 1'b1, (i == 0), 1'b0, 1'b0);
        chk("rs_partial_count", {26'h0, bit_count}, 32'd10);
        exp_q.push_back(32'h0000FFFF);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("rs_count_after_restart", {26'h0, bit_count}, 32'd1);
        chk("rs_busy", {31'h0, busy}, 32'd1);
        for (int i = 1; i < 32; i++) cycle((i < 16), 1'b1, 1'b0, 1'b0, 1'b0);
        check_out("rs_p_out");
        chk("rs_out_valid", {31'h0, out_valid}, 32'd1);
        chk("rs_overrun", {31'h0, overrun}, 32'd0);
        chk("sb_drained", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
